eth_pcs_rx_descrambler: RTL and testbench
=========================================

# eth_pcs_rx_descrambler

Receive-path PCS stage directly downstream of the RX gearbox. It takes the gearbox's 32-bit data words and 2-bit sync headers and descrambles the payload with the self-synchronizing 10GBASE-R descrambler (1 + x^39 + x^58). It reassembles each pair of data words into one 66-bit block (header plus 64 data bits) for the 64b/66b decoder. It also flags blocks whose header is missing.

## Interface
- W_DATA, 32: gearbox word width; only 32 is supported (2 words per block).
- W_SYNC, 2: sync header width.
- W_BLK, 64: block payload width, equal to 2*W_DATA.
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_grbx_hdr_valid  in  1  i_grbx_hdr carries the header of the next block.
- i_grbx_hdr  in  W_SYNC  sync header, transmitted first bit in [0].
- i_grbx_data_valid  in  1  i_grbx_data holds 32 scrambled payload bits.
- i_grbx_data  in  W_DATA  scrambled payload, earliest bit in [0].
- i_rx_lock  in  1  block lock from block sync; low means alignment is not trusted.
- o_blk_valid  out  1  single-cycle strobe: block outputs are valid.
- o_blk_hdr  out  W_SYNC  header of the emitted block.
- o_blk_data  out  W_BLK  descrambled payload; first word in [31:0], second word in [63:32].
- o_hdr_err  out  1  single-cycle strobe with o_blk_valid: the block was assembled without a captured header.

## Operation
- Descrambler state S[57:0], with S[0] the most recently received scrambled bit.
- On each cycle with i_grbx_data_valid=1, process bits i=0..31 in order:
  - out[i] = x[i] ^ S[38] ^ S[57]
  - then S = {S[56:0], x[i]}, where x is i_grbx_data.
- S updates on every valid word regardless of i_rx_lock, so the descrambler resynchronizes itself within 58 bits.
- The 32 bit steps are unrolled combinationally into one cycle.
- Header capture: when i_grbx_hdr_valid=1, load hdr_reg and set hdr_pend=1.
  - A header arriving while hdr_pend=1 overwrites hdr_reg; no error is raised.
- Word assembly FSM:
  - LOW state: on a valid word, store the descrambled word in low_reg and go to HIGH.
  - HIGH state: on a valid word, emit a block on the next cycle, then go to LOW.
    - o_blk_data = {descrambled word, low_reg}.
    - o_blk_hdr = hdr_reg if hdr_pend, else 2'b00.
    - o_hdr_err = !hdr_pend.
    - hdr_pend is cleared unless a new header arrives in the same cycle; the new header is kept pending.
- Simultaneous header and word in LOW state: the header belongs to the block being started. Capture it before the emit logic evaluates pend.
- Lock: while i_rx_lock=0:
  - the FSM is forced to LOW and hdr_pend is cleared;
  - no block is emitted.
  - Emission resumes with the first word after lock rises.
- A lock drop in the HIGH state discards the half-assembled block silently.
- If i_grbx_data_valid=0, the FSM and the registers hold their values.

## Timing
- Reset values:
  - o_blk_valid=0, o_hdr_err=0, o_blk_hdr=0, o_blk_data=0;
  - S=0, FSM=LOW, hdr_pend=0, hdr_reg=0, low_reg=0.
- All outputs are registered.
- Latency: o_blk_valid rises exactly 1 cycle after the cycle that accepts the HIGH word.
- Output fields hold their values between strobes; o_blk_valid and o_hdr_err are high for exactly 1 cycle.
- Throughput: at most 1 block every 2 cycles, which matches the gearbox rate. Gearbox bubbles (data_valid=0) only stretch the interval.
- Reset mid-block takes effect on the next edge: a partial block is dropped and S is cleared. The first block after reset has correct data only once 58 scrambled bits have passed.

## Test plan
- All-zero scrambled input, lock high, header 2'b01 every 2 words:
  - o_blk_data=64'h0 and o_blk_hdr=01;
  - one o_blk_valid every 2 valid words, 1 cycle after the second word.
- Scrambled stream from a golden 1+x^39+x^58 scrambler on random payload, headers 01/10 alternating:
  - after the first block, every o_blk_data equals the original payload;
  - every o_blk_hdr matches the sent header.
- Data-valid bubble between LOW and HIGH words:
  - the block is emitted exactly 1 cycle after the delayed HIGH word;
  - its content is unchanged versus the no-bubble case.
- Two blocks where the second block's header is withheld:
  - the second emission has o_hdr_err=1 and o_blk_hdr=00;
  - the first has o_hdr_err=0.
- i_rx_lock dropped for 3 cycles after a LOW word:
  - no block is emitted for that partial block;
  - the next complete pair after lock returns emits normally.
- i_reset pulsed in the HIGH state:
  - outputs read 0 the next cycle and no block is emitted for the pending word;
  - descrambled output is correct again after 58 input bits.

Source files
------------

// File: rtl/eth_pcs_rx_descrambler.sv
// 10GBASE-R receive descrambler (1 + x^39 + x^58) with 66-bit block reassembly.
// Two 32-bit gearbox words plus a captured sync header form one block.
module eth_pcs_rx_descrambler #(
  parameter int W_DATA = 32,
  parameter int W_SYNC = 2,
  parameter int W_BLK  = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_grbx_hdr_valid,
  input  logic [W_SYNC-1:0] i_grbx_hdr,
  input  logic              i_grbx_data_valid,
  input  logic [W_DATA-1:0] i_grbx_data,
  input  logic              i_rx_lock,
  output logic              o_blk_valid,
  output logic [W_SYNC-1:0] o_blk_hdr,
  output logic [W_BLK-1:0]  o_blk_data,
  output logic              o_hdr_err
);

  typedef enum logic {ST_LOW, ST_HIGH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [57:0]         r_scr;
  logic [57:0]         w_scr_nxt;
  logic [W_DATA-1:0]   w_desc;
  logic [W_DATA-1:0]   r_low;
  logic [W_SYNC-1:0]   r_hdr;
  logic                r_hdr_pend;
  logic                w_hdr_pend_nxt;
  logic                w_emit;
  logic                w_load_low;

  // Bit-serial descrambler unrolled over the word; S[0] is the newest scrambled bit.
  always_comb begin
    w_scr_nxt = r_scr;
    w_desc    = '0;
    for (int unsigned i = 0; i < W_DATA; i++) begin
      w_desc[i] = i_grbx_data[i] ^ w_scr_nxt[38] ^ w_scr_nxt[57];
      w_scr_nxt = {w_scr_nxt[56:0], i_grbx_data[i]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_LOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_rx_lock) begin
      w_state_nxt = ST_LOW;
    end else if (i_grbx_data_valid) begin
      w_state_nxt = (r_state == ST_LOW) ? ST_HIGH : ST_LOW;
    end
  end

  // A header arriving with the HIGH word belongs to the next block, so it stays pending.
  always_comb begin
    w_emit         = (r_state == ST_HIGH) && i_grbx_data_valid && i_rx_lock;
    w_load_low     = (r_state == ST_LOW) && i_grbx_data_valid && i_rx_lock;
    w_hdr_pend_nxt = r_hdr_pend;
    if (!i_rx_lock) begin
      w_hdr_pend_nxt = 1'b0;
    end else if (i_grbx_hdr_valid) begin
      w_hdr_pend_nxt = 1'b1;
    end else if (w_emit) begin
      w_hdr_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scr       <= '0;
      r_low       <= '0;
      r_hdr       <= '0;
      r_hdr_pend  <= 1'b0;
      o_blk_valid <= 1'b0;
      o_hdr_err   <= 1'b0;
      o_blk_hdr   <= '0;
      o_blk_data  <= '0;
    end else begin
      r_hdr_pend  <= w_hdr_pend_nxt;
      o_blk_valid <= w_emit;
      o_hdr_err   <= w_emit && !r_hdr_pend;
      if (i_grbx_data_valid) begin
        r_scr <= w_scr_nxt;
      end
      if (i_grbx_hdr_valid) begin
        r_hdr <= i_grbx_hdr;
      end
      if (w_load_low) begin
        r_low <= w_desc;
      end
      if (w_emit) begin
        o_blk_data <= {w_desc, r_low};
        o_blk_hdr  <= r_hdr_pend ? r_hdr : '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_pcs_rx_descrambler.sv
// Randomized bench for eth_pcs_rx_descrambler against a bit-history reference model
// and a golden 1+x^39+x^58 transmit scrambler.
module tb_eth_pcs_rx_descrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic        hv;
  logic [1:0]  hdr;
  logic        dv;
  logic [31:0] data;
  logic        lock;
  logic        blk_valid;
  logic [1:0]  blk_hdr;
  logic [63:0] blk_data;
  logic        hdr_err;

  always #5 clk = ~clk;

  eth_pcs_rx_descrambler #(.W_DATA(32), .W_SYNC(2), .W_BLK(64)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_grbx_hdr_valid  (hv),
    .i_grbx_hdr        (hdr),
    .i_grbx_data_valid (dv),
    .i_grbx_data       (data),
    .i_rx_lock         (lock),
    .o_blk_valid       (blk_valid),
    .o_blk_hdr         (blk_hdr),
    .o_blk_data        (blk_data),
    .o_hdr_err         (hdr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: every scrambled bit since reset is kept; descrambled bit t is
  // x[t] ^ x[t-39] ^ x[t-58], with bits before reset taken as zero.
  bit          rx_hist[$];
  bit          tx_hist[$];
  logic        m_half;
  logic [31:0] m_low;
  logic        m_pend;
  logic [1:0]  m_hreg;
  logic        e_valid, e_err;
  logic [1:0]  e_hdr;
  logic [63:0] e_data;

  function automatic logic [31:0] scramble(input logic [31:0] p);
    logic [31:0] s;
    for (int i = 0; i < 32; i++) begin
      s[i] = p[i] ^ tx_hist[tx_hist.size()-39] ^ tx_hist[tx_hist.size()-58];
      tx_hist.push_back(s[i]);
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_descramble(input logic [31:0] x);
    logic [31:0] w;
    int n;
    for (int i = 0; i < 32; i++) begin
      n = rx_hist.size();
      w[i] = x[i] ^ ((n >= 39) ? rx_hist[n-39] : 1'b0) ^ ((n >= 58) ? rx_hist[n-58] : 1'b0);
      rx_hist.push_back(x[i]);
    end
    return w;
  endfunction

  task automatic model_reset();
    rx_hist.delete();
    m_half = 0; m_low = '0; m_pend = 0; m_hreg = '0;
    e_valid = 0; e_err = 0; e_hdr = '0; e_data = '0;
  endtask

  task automatic step(input logic r, input logic h_v, input logic [1:0] h,
                      input logic d_v, input logic [31:0] d, input logic lk);
    logic [31:0] w;
    logic emit;
    rst = r; hv = h_v; hdr = h; dv = d_v; data = d; lock = lk;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      w = '0;
      if (d_v) w = ref_descramble(d);
      emit = d_v && lk && m_half;
      e_valid = emit;
      e_err = emit && !m_pend;
      if (emit) begin
        e_hdr  = m_pend ? m_hreg : 2'b00;
        e_data = {w, m_low};
      end
      if (!lk) m_pend = 0;
      else if (h_v) m_pend = 1;
      else if (emit) m_pend = 0;
      if (h_v) m_hreg = h;
      if (!lk) m_half = 0;
      else if (d_v) begin
        if (!m_half) m_low = w;
        m_half = !m_half;
      end
    end
    #1;
    check("valid", {63'd0, blk_valid}, {63'd0, e_valid});
    check("hdr_err", {63'd0, hdr_err}, {63'd0, e_err});
    check("blk_hdr", {62'd0, blk_hdr}, {62'd0, e_hdr});
    check("blk_data", blk_data, e_data);
  endtask

  task automatic idle(input logic lk);
    step(1'b0, 1'b0, 2'b00, 1'b0, '0, lk);
  endtask

  initial begin
    logic [31:0] p0, p1, s0, s1;
    logic [1:0]  h;
    logic [63:0] pay[$];
    int nblk;
    model_reset();
    rst = 1; hv = 0; hdr = '0; dv = 0; data = '0; lock = 0;
    for (int i = 0; i < 58; i++) tx_hist.push_back(bit'($urandom_range(1)));

    step(1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0);
    check("reset_valid", {63'd0, blk_valid}, 64'd0);
    check("reset_data", blk_data, 64'd0);

    // all-zero scrambled stream
    for (int b = 0; b < 6; b++) begin
      step(1'b0, 1'b1, 2'b01, 1'b1, '0, 1'b1);
      check("zero_gap", {63'd0, blk_valid}, 64'd0);
      step(1'b0, 1'b0, 2'b00, 1'b1, '0, 1'b1);
      check("zero_strobe", {63'd0, blk_valid}, 64'd1);
      check("zero_data", blk_data, 64'd0);
      check("zero_hdr", {62'd0, blk_hdr}, 64'd1);
    end

    // golden scrambler on random payload, alternating headers, random bubbles
    nblk = 0;
    for (int b = 0; b < 24; b++) begin
      p0 = $urandom; p1 = $urandom;
      s0 = scramble(p0); s1 = scramble(p1);
      h = b[0] ? 2'b10 : 2'b01;
      pay.push_back({p1, p0});
      if ($urandom_range(3) == 0) idle(1'b1);
      step(1'b0, 1'b1, h, 1'b1, s0, 1'b1);
      for (int k = 0; k < int'($urandom_range(2)); k++) idle(1'b1);
      step(1'b0, 1'b0, 2'b00, 1'b1, s1, 1'b1);
      check("gold_strobe", {63'd0, blk_valid}, 64'd1);
      check("gold_hdr", {62'd0, blk_hdr}, {62'd0, h});
      if (nblk > 0) check("gold_payload", blk_data, pay[0]);
      void'(pay.pop_front());
      nblk++;
    end

    // second block's header withheld
    step(1'b0, 1'b1, 2'b10, 1'b1, $urandom, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b1, $urandom, 1'b1);
    check("hdr_ok_err", {63'd0, hdr_err}, 64'd0);
    step(1'b0, 1'b0, 2'b00, 1'b1, $urandom, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b1, $urandom, 1'b1);
    check("hdr_missing_err", {63'd0, hdr_err}, 64'd1);
    check("hdr_missing_hdr", {62'd0, blk_hdr}, 64'd0);

    // lock dropped for 3 cycles after a LOW word
    step(1'b0, 1'b1, 2'b01, 1'b1, $urandom, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 2'b00, 1'b1, $urandom, 1'b0);
      check("lock_quiet", {63'd0, blk_valid}, 64'd0);
    end
    step(1'b0, 1'b1, 2'b10, 1'b1, $urandom, 1'b1);
    check("lock_low_word", {63'd0, blk_valid}, 64'd0);
    step(1'b0, 1'b0, 2'b00, 1'b1, $urandom, 1'b1);
    check("lock_resume", {63'd0, blk_valid}, 64'd1);
    check("lock_resume_hdr", {62'd0, blk_hdr}, 64'd2);

    // reset while in the HIGH state with the HIGH word present
    step(1'b0, 1'b1, 2'b01, 1'b1, $urandom, 1'b1);
    step(1'b1, 1'b0, 2'b00, 1'b1, $urandom, 1'b1);
    check("rst_mid_valid", {63'd0, blk_valid}, 64'd0);
    check("rst_mid_data", blk_data, 64'd0);
    for (int b = 0; b < 4; b++) begin
      p0 = $urandom; p1 = $urandom;
      s0 = scramble(p0); s1 = scramble(p1);
      step(1'b0, 1'b1, 2'b01, 1'b1, s0, 1'b1);
      step(1'b0, 1'b0, 2'b00, 1'b1, s1, 1'b1);
      if (b > 0) check("rst_resync", blk_data, {p1, p0});
    end

    // random mix of headers, bubbles, lock drops and resets
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(60) == 0), ($urandom_range(2) == 0), 2'($urandom),
           ($urandom_range(3) != 0), $urandom, ($urandom_range(9) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
